// File: rtl/tg_pkg.sv
// Shared types and constants for the timing-generator pulse sequencer.
package tg_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        RUN  = 2'd2
    } tg_state_e;

    // Width of the completed-sequence counter shown on DA_test4
    localparam int DA4_W = 4;

endpackage

// File: rtl/tg_pulse_seq_if.sv
// Start/configuration/pulse bundle between the sequencer and its environment.
interface tg_pulse_seq_if
    import tg_pkg::*;
#(
    parameter int W = 4
);
    logic             TG_start;
    logic [W-1:0]     B_test1;
    logic [W-1:0]     B_test2;
    logic [W-1:0]     B_test3;
    logic             DA_test1;
    logic             DA_test2;
    logic             DA_test3;
    logic [DA4_W-1:0] DA_test4;
    logic             TG_busy;
    logic             TG_err;

    modport master (
        output TG_start, B_test1, B_test2, B_test3,
        input  DA_test1, DA_test2, DA_test3, DA_test4, TG_busy, TG_err
    );

    modport slave (
        input  TG_start, B_test1, B_test2, B_test3,
        output DA_test1, DA_test2, DA_test3, DA_test4, TG_busy, TG_err
    );
endinterface

// File: rtl/tg_width_cnt.sv
// Loadable W-bit down-counter; nz_o is a registered "counter is nonzero" flag
// that is high in the same cycle the loaded value becomes visible.
module tg_width_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         nz_o,
    output logic         zero_next_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         nz_q;

    // Next count: load wins, otherwise decrement until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter and output flag registers; flag tracks the new count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            nz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            nz_q  <= (cnt_d != '0);
        end
    end

    assign nz_o        = nz_q;
    // Lets the FSM leave RUN so that IDLE coincides with all pulses low
    assign zero_next_o = (cnt_d == '0);
endmodule

// File: rtl/tg_pulse_seq.sv
// Timing-generator pulse sequencer: DA_test1 pulse, two follower pulses that
// rise one cycle later, and a modulo-16 count of completed sequences.
module tg_pulse_seq
    import tg_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           C_purst,
    tg_pulse_seq_if.slave  bus
);
    tg_state_e        state_q;
    logic [W-1:0]     b2_q, b3_q;
    logic [DA4_W-1:0] seq_cnt_q;
    logic             busy_q, err_q;

    logic cfg_ok, accept, lead;
    logic z1, z2, z3, all_done;

    assign cfg_ok   = (bus.B_test1 != '0) && (bus.B_test2 != '0) && (bus.B_test3 != '0);
    assign accept   = (state_q == IDLE) && bus.TG_start && cfg_ok;
    assign lead     = (state_q == LEAD);
    assign all_done = z1 && z2 && z3;

    tg_width_cnt #(.W(W)) u_cnt1 (
        .clk         (clk),
        .rst         (C_purst),
        .load_i      (accept),
        .val_i       (bus.B_test1),
        .nz_o        (bus.DA_test1),
        .zero_next_o (z1)
    );

    tg_width_cnt #(.W(W)) u_cnt2 (
        .clk         (clk),
        .rst         (C_purst),
        .load_i      (lead),
        .val_i       (b2_q),
        .nz_o        (bus.DA_test2),
        .zero_next_o (z2)
    );

    tg_width_cnt #(.W(W)) u_cnt3 (
        .clk         (clk),
        .rst         (C_purst),
        .load_i      (lead),
        .val_i       (b3_q),
        .nz_o        (bus.DA_test3),
        .zero_next_o (z3)
    );

    // Sequencer FSM with registered busy/error/count outputs
    always_ff @(posedge clk or posedge C_purst) begin
        if (C_purst) begin
            state_q   <= IDLE;
            b2_q      <= '0;
            b3_q      <= '0;
            seq_cnt_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.TG_start) begin
                        if (cfg_ok) begin
                            b2_q    <= bus.B_test2;
                            b3_q    <= bus.B_test3;
                            busy_q  <= 1'b1;
                            state_q <= LEAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LEAD: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (all_done) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        seq_cnt_q <= seq_cnt_q + DA4_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.DA_test4 = seq_cnt_q;
    assign bus.TG_busy  = busy_q;
    assign bus.TG_err   = err_q;
endmodule

// File: doc/tg_pulse_seq.md
# tg_pulse_seq

Timing-generator pulse sequencer: on a start request it emits the DA_test1 pulse and the derived DA_test2/DA_test3 pulses with programmable widths, plus a 4-bit completed-sequence count on DA_test4. It sits directly upstream of the TG assertion checker, which consumes DA_test1..DA_test4 and checks their edge relationships against the same B_test configuration words.

## Interface
- W, default 4: width of the B_test width-configuration words and of their internal down-counters.
- clk  in  1  single clock; all state updates on the rising edge.
- C_purst  in  1  asynchronous active-high reset; it clears everything immediately.
- TG_start  in  1  level-sampled start request.
- B_test1  in  W  DA_test1 high width, in cycles.
- B_test2  in  W  DA_test2 high width, in cycles.
- B_test3  in  W  DA_test3 high width, in cycles.
- DA_test1  out  1  primary pulse.
- DA_test2  out  1  follower pulse; it rises one cycle after DA_test1.
- DA_test3  out  1  follower pulse; it rises one cycle after DA_test1.
- DA_test4  out  4  count of completed sequences, modulo 16.
- TG_busy  out  1  a sequence is in progress.
- TG_err  out  1  one-cycle pulse when a start is rejected because its configuration is illegal.

## Operation
- FSM states are IDLE, LEAD and RUN.
- Reset values: state IDLE; DA_test1..3 = 0; DA_test4 = 0; TG_busy = 0; TG_err = 0; all counters 0.
- In IDLE, TG_start = 1 at cycle t with B_test1, B_test2 and B_test3 all nonzero is an accepted start:
  - B_test1..3 are latched at t; later changes are ignored until the next start.
  - The DA_test1 counter is loaded with B_test1 at t.
  - The state goes to LEAD.
- In IDLE, TG_start = 1 with any B_test word equal to 0 is rejected:
  - TG_err = 1 at t+1 only.
  - No outputs toggle and the state stays IDLE.
- LEAD lasts one cycle. It loads the DA_test2 and DA_test3 counters with the latched widths, then goes to RUN.
- RUN stays until all three counters are 0, then goes to IDLE and increments DA_test4, which wraps 15 → 0.
- Each DA output is registered and equals (its counter ≠ 0). Each counter decrements by 1 per cycle while nonzero.
- TG_start is ignored in LEAD and RUN, and also in the cycle the FSM re-enters IDLE; acceptance happens only when the FSM is already in IDLE.
- An active C_purst clears all outputs and counters at once, including mid-sequence. The in-flight sequence is not counted.

## Timing
- For an accepted start at cycle t:
  - DA_test1 is high over t+1 .. t+B1 and low at t+B1+1.
  - DA_test2 is high over t+2 .. t+1+B2.
  - DA_test3 is high over t+2 .. t+1+B3.
- End cycle E = max(t+1+B1, t+2+B2, t+2+B3), the first cycle in which all three outputs are low.
- TG_busy is high over t+1 .. E-1. At E: TG_busy = 0, DA_test4 shows the incremented value, and the state is IDLE.
- The earliest next accepted start is at E, giving a next DA_test1 rise at E+1. DA_test1 is therefore low for at least one cycle between pulses.
- Width arithmetic is unsigned W-bit. The maximum width is 2^W−1 cycles, with no saturation logic needed.

## Structure
- Package tg_pkg holds:
  - the state enum tg_state_e (IDLE, LEAD, RUN);
  - the localparam for the DA_test4 width (4).
- Sub-module tg_width_cnt: a loadable W-bit down-counter with a registered "nonzero" output. It is instantiated three times, once per DA output.

## Test plan
- **Basic sequence:** B1=5, B2=3, B3=7, start at cycle 10 → DA_test1 high 11–15; DA_test2 high 12–14; DA_test3 high 12–18; TG_busy 11–18; DA_test4 = 1 at 19.
- **Back-to-back:** B1=B2=B3=1 with TG_start held high from t → DA_test1 rises at t+1, t+4, t+7 (period 3); DA_test2/3 are high at t+2, t+5, …
- **Illegal config:** B2=0 with start at t → TG_err = 1 at t+1 only; all DA outputs stay 0; DA_test4 is unchanged.
- **Start while busy:** B1=8 (B2=B3=1), pulse TG_start at t+3 during RUN → ignored; only one DA_test1 rise; DA_test4 increments once.
- **Mid-sequence config change:** B1=4, start at t; B1 changed to 9 at t+2 → the DA_test1 fall still occurs at t+5.
- **Reset and wrap:**
  - Run 16 sequences → DA_test4 wraps 15 → 0.
  - Assert C_purst while DA_test1 is high → all outputs are 0 immediately; after release, a start behaves like the first sequence.
